// File: rtl/registrador_pkg.sv
// Shared mode constants and FSM state type for the universal shift register.
package registrador_pkg;

   localparam logic [1:0] CH_LOAD = 2'b00;
   localparam logic [1:0] CH_DIR  = 2'b01;
   localparam logic [1:0] CH_ESQ  = 2'b10;
   localparam logic [1:0] CH_HOLD = 2'b11;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } estado_t;

endpackage

// File: rtl/celula_registrador.sv
// One bit of the universal register: 4:1 mux between load value, neighbours and own state.
module celula_registrador
   import registrador_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] sel,
   input  logic       valor,
   input  logic       viz_esq,
   input  logic       viz_dir,
   output logic       q
);

   // viz_esq is the bit above (feeds shift right), viz_dir the bit below (feeds shift left)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case (sel)
            CH_LOAD: q <= valor;
            CH_DIR:  q <= viz_esq;
            CH_ESQ:  q <= viz_dir;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/registrador_universal.sv
// Universal shift register with load/shift/hold and a counted burst-shift engine.
// Optional rotation via macro REGISTRADOR_ROTATE_EN (adds the rot port).
//
// state | meaning
// IDLE  | ch applied directly; start with a shift mode launches a burst
// SHIFT | one shift per edge in the latched direction until count expires
module registrador_universal
   import registrador_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH) + 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       ch,
   input  logic [WIDTH-1:0] valores_registrador,
   input  logic             entrada_msb,
   input  logic             entrada_lsb,
   input  logic             start,
   input  logic [CW-1:0]    qtd,
`ifdef REGISTRADOR_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             saida_msb,
   output logic             saida_lsb,
   output logic             busy,
   output logic             done
);

   estado_t       estado;
   logic [1:0]    dir_lat;
   logic [CW-1:0] cnt;
   logic          aceita;
   logic [1:0]    sel;
   logic          rot_eff;
   logic          borda_msb;
   logic          borda_lsb;

   assign aceita = (estado == IDLE) && start && ((ch == CH_DIR) || (ch == CH_ESQ));

   // The accepting edge only latches the burst; q holds there
   always_comb begin
      sel = ch;
      if (estado == SHIFT)
         sel = dir_lat;
      else if (aceita)
         sel = CH_HOLD;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado  <= IDLE;
         dir_lat <= CH_HOLD;
         cnt     <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (estado)
            IDLE: begin
               if (aceita) begin
                  dir_lat <= ch;
                  cnt     <= qtd;
                  if (qtd == '0)
                     done <= 1'b1;
                  else
                     estado <= SHIFT;
               end
            end
            SHIFT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  estado <= IDLE;
                  done   <= 1'b1;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

`ifdef REGISTRADOR_ROTATE_EN
   logic rot_lat;

   always_ff @(posedge clk) begin
      if (!rst_n)
         rot_lat <= 1'b0;
      else if (aceita)
         rot_lat <= rot;
   end

   assign rot_eff = (estado == SHIFT) ? rot_lat : rot;
`else
   assign rot_eff = 1'b0;
`endif

   assign borda_msb = rot_eff ? q[0]       : entrada_msb;
   assign borda_lsb = rot_eff ? q[WIDTH-1] : entrada_lsb;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic viz_esq;
      logic viz_dir;

      if (i == WIDTH - 1) begin : g_topo
         assign viz_esq = borda_msb;
      end else begin : g_meio_e
         assign viz_esq = q[i+1];
      end

      if (i == 0) begin : g_base
         assign viz_dir = borda_lsb;
      end else begin : g_meio_d
         assign viz_dir = q[i-1];
      end

      celula_registrador u_cel (
         .clk     (clk),
         .rst_n   (rst_n),
         .sel     (sel),
         .valor   (valores_registrador[i]),
         .viz_esq (viz_esq),
         .viz_dir (viz_dir),
         .q       (q[i])
      );
   end

   assign saida_msb = q[WIDTH-1];
   assign saida_lsb = q[0];
   assign busy      = (estado == SHIFT);

endmodule

// File: doc/registrador_universal.md
# registrador_universal

Parametrised universal shift register, the multi-bit successor to the single-bit load/shift cell used in the datapath. It offers parallel load, shift right, shift left and hold, with serial in/out at both ends for chaining. It also has a burst engine that performs a programmed number of consecutive shifts under a start/busy/done handshake. It sits between the operand-entry logic and the display/ALU stages.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `CW`, `$clog2(WIDTH)+1`, width of the burst shift count (derived, not overridden)

- `clk` in 1: single clock, all state updates on posedge
- `rst_n` in 1: synchronous, active-low reset
- `ch` in 2: mode select
  - 00 parallel load
  - 01 shift right (toward LSB)
  - 10 shift left (toward MSB)
  - 11 hold
- `valores_registrador` in WIDTH: parallel load data
- `entrada_msb` in 1: serial input entering bit WIDTH-1 on shift right
- `entrada_lsb` in 1: serial input entering bit 0 on shift left
- `start` in 1: burst request, sampled in IDLE only
- `qtd` in CW: number of shifts for the burst
- `q` out WIDTH: register contents
- `saida_msb` out 1: equals `q[WIDTH-1]`
- `saida_lsb` out 1: equals `q[0]`
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse at burst completion

## Operation
- Reset (`rst_n`=0 at an edge) forces:
  - `q`=0, `busy`=0, `done`=0, FSM state IDLE
  - This takes priority over everything and aborts any burst in progress with no `done` pulse.
- Shift right: `q` ← {`entrada_msb`, `q[WIDTH-1:1]`}.
- Shift left: `q` ← {`q[WIDTH-2:0]`, `entrada_lsb`}.
- Serial inputs are sampled at the edge where the shift is performed.
- FSM has two states, IDLE and SHIFT.
- IDLE, `start`=0: `ch` applies directly each edge. Mode 11 leaves `q` unchanged.
- IDLE, `start`=1, `ch`∈{01,10}:
  - Latch direction and `qtd`; `q` is unchanged at this edge.
  - If `qtd`≠0, go to SHIFT.
  - If `qtd`=0, stay in IDLE and pulse `done`.
- IDLE, `start`=1, `ch`∈{00,11}: `start` is ignored and `ch` applies normally.
- SHIFT:
  - One shift per edge in the latched direction; the remaining count decrements.
  - `ch`, `start`, `valores_registrador` and `qtd` are ignored.
  - After the last shift, return to IDLE and pulse `done`.
- `qtd` > WIDTH is legal. Bits that shift out are lost unless rotation is enabled (see Configuration).
- `busy` = (state == SHIFT). `done` is registered.

## Timing
- Direct ops: `q` updates at the same edge that samples `ch`, so latency is 1 edge.
- Burst with `start` sampled at edge k and `qtd`=N>0:
  - Shifts occur at edges k+1 … k+N.
  - `busy` is high from after edge k until after edge k+N.
  - `done` is high for exactly the cycle following edge k+N; `busy` is already low in that cycle.
- Burst with `qtd`=0: `done` is high for the cycle following edge k, and `busy` never asserts.
- A new `start` may be accepted in the same cycle that `done` is high (back-to-back bursts).
- `saida_msb` and `saida_lsb` are combinational copies of `q` bits with no added latency.

## Configuration
- Macro `REGISTRADOR_ROTATE_EN`.
- Defined:
  - Adds input port `rot` (1 bit), sampled with `ch` in IDLE and latched with the burst direction.
  - With `rot`=1, shift right feeds `q[0]` into the MSB and shift left feeds `q[WIDTH-1]` into the LSB; the serial inputs are ignored.
  - A burst with `qtd`=WIDTH and `rot`=1 restores the original `q`.
- Undefined: no `rot` port, and shifts always use `entrada_msb`/`entrada_lsb`.

## Structure
- Package `registrador_pkg` holds:
  - Mode constants `CH_LOAD`, `CH_DIR`, `CH_ESQ`, `CH_HOLD`
  - FSM state enum (IDLE, SHIFT)
- Sub-module `celula_registrador`: one bit with a 4:1 mux (load value, left neighbour, right neighbour, own q). It is instantiated WIDTH times via generate.
- The FSM, counter and edge-bit neighbour selection (serial input vs rotate) live in the top module.

## Test plan
- Reset mid-burst (WIDTH=8): load 8'hA5, start right burst `qtd`=5, assert `rst_n`=0 after 2 shifts → `q`=0, `busy`=0, no `done` pulse.
- Load then shift right: load 8'hA5, one cycle of `ch`=01 with `entrada_msb`=1 → `q`=8'hD2, `saida_lsb`=0.
- Burst left, `qtd`=3, `entrada_lsb`=0, from 8'h81 → `busy` high 3 cycles, `q`=8'h08, `done` high 1 cycle after the last shift.
- Burst with `qtd`=0 → `done` pulse next cycle, `busy` never high, `q` unchanged. A `ch`=00 `start` loads and produces no `done`.
- Activity during a burst: toggle `ch` and `start` mid-burst → ignored, burst completes. A second `start` in the `done` cycle is accepted.
- `REGISTRADOR_ROTATE_EN` defined: right burst from 8'h81 with `qtd`=8, `rot`=1 → `q` back to 8'h81. Left single shift of 8'h81 with `rot`=1 → 8'h03.
